// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry integer register file: selects the write-back value,
// commits it, and serves two ID read ports (optionally bypassed) plus a debug port.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk_WB,
    input  logic              rst_WB,
    input  logic [DATA_W-1:0] PC4_in_WB,
    input  logic [ADDR_W-1:0] Rd_addr_in_WB,
    input  logic [DATA_W-1:0] ALU_in_WB,
    input  logic [DATA_W-1:0] DMem_data_in_WB,
    input  logic [1:0]        MemtoReg_in_WB,
    input  logic              RegWrite_in_WB,
    input  logic [ADDR_W-1:0] Rs1_addr_ID,
    input  logic [ADDR_W-1:0] Rs2_addr_ID,
    input  logic [ADDR_W-1:0] Dbg_addr,
    output logic [DATA_W-1:0] Rs1_data_ID,
    output logic [DATA_W-1:0] Rs2_data_ID,
    output logic [DATA_W-1:0] Dbg_data,
    output logic [DATA_W-1:0] WB_data_out,
    output logic [31:0]       WB_commit_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              commit;
    logic              bypassOk;

    function automatic logic [DATA_W-1:0] selectWb(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] dmem,
        input logic [DATA_W-1:0] pc4
    );
        case (sel)
            2'b00:   return alu;
            2'b01:   return dmem;
            2'b10:   return pc4;
            default: return '0;
        endcase
    endfunction

    // x0 is hardwired: a read of address 0 ignores storage and bypass alike.
    function automatic logic [DATA_W-1:0] readPort(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              hit,
        input logic [DATA_W-1:0] fresh
    );
        if (addr == '0)
            return '0;
        else if (hit)
            return fresh;
        else
            return stored;
    endfunction

    assign WB_data_out = selectWb(MemtoReg_in_WB, ALU_in_WB, DMem_data_in_WB, PC4_in_WB);
    assign commit      = RegWrite_in_WB && (Rd_addr_in_WB != '0);
    assign bypassOk    = (BYPASS != 0) && commit && !rst_WB;

    always_comb begin
        Rs1_data_ID = readPort(Rs1_addr_ID, regs[Rs1_addr_ID],
                               bypassOk && (Rs1_addr_ID == Rd_addr_in_WB), WB_data_out);
        Rs2_data_ID = readPort(Rs2_addr_ID, regs[Rs2_addr_ID],
                               bypassOk && (Rs2_addr_ID == Rd_addr_in_WB), WB_data_out);
        Dbg_data    = readPort(Dbg_addr, regs[Dbg_addr], 1'b0, WB_data_out);
    end

    // Reset wins over a simultaneous commit; the pending write is discarded.
    always_ff @(posedge clk_WB) begin
        if (rst_WB) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            WB_commit_cnt <= '0;
        end else if (commit) begin
            regs[Rd_addr_in_WB] <= WB_data_out;
            WB_commit_cnt       <= WB_commit_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: one instance with bypass, one without, sharing stimulus.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc4, alu, dmem;
    logic [4:0]  rd, rs1, rs2, dbgA;
    logic [1:0]  sel;
    logic        we;

    logic [31:0] rs1Byp, rs2Byp, dbgByp, wbByp, cntByp;
    logic [31:0] rs1Raw, rs2Raw, dbgRaw, wbRaw, cntRaw;

    int errors = 0;
    int checks = 0;

    logic [31:0] modelRegs [32];
    logic [31:0] modelCnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dutByp (
        .clk_WB(clk), .rst_WB(rst), .PC4_in_WB(pc4), .Rd_addr_in_WB(rd),
        .ALU_in_WB(alu), .DMem_data_in_WB(dmem), .MemtoReg_in_WB(sel),
        .RegWrite_in_WB(we), .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Dbg_addr(dbgA),
        .Rs1_data_ID(rs1Byp), .Rs2_data_ID(rs2Byp), .Dbg_data(dbgByp),
        .WB_data_out(wbByp), .WB_commit_cnt(cntByp)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dutRaw (
        .clk_WB(clk), .rst_WB(rst), .PC4_in_WB(pc4), .Rd_addr_in_WB(rd),
        .ALU_in_WB(alu), .DMem_data_in_WB(dmem), .MemtoReg_in_WB(sel),
        .RegWrite_in_WB(we), .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Dbg_addr(dbgA),
        .Rs1_data_ID(rs1Raw), .Rs2_data_ID(rs2Raw), .Dbg_data(dbgRaw),
        .WB_data_out(wbRaw), .WB_commit_cnt(cntRaw)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the write-back value straight from the select rules.
    function automatic logic [31:0] modelWb();
        if (sel == 2'd0) return alu;
        if (sel == 2'd1) return dmem;
        if (sel == 2'd2) return pc4;
        return 32'd0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] addr, input bit bypassOn);
        if (addr == 5'd0) return 32'd0;
        if (bypassOn && !rst && we && rd != 5'd0 && addr == rd) return modelWb();
        return modelRegs[addr];
    endfunction

    task automatic modelEdge();
        if (rst) begin
            foreach (modelRegs[i]) modelRegs[i] = 32'd0;
            modelCnt = 32'd0;
        end else if (we && rd != 5'd0) begin
            modelRegs[rd] = modelWb();
            modelCnt      = modelCnt + 32'd1;
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] d, input logic [31:0] a, input logic [1:0] s,
                         input logic w, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] dg);
        rd = d; alu = a; sel = s; we = w; rs1 = r1; rs2 = r2; dbgA = dg;
        #3;
    endtask

    task automatic randomStep();
        rst  = ($urandom_range(0, 39) == 0);
        we   = ($urandom_range(0, 3) != 0);
        rd   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        rs1  = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 3));
        rs2  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
        dbgA = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom);
        sel  = 2'($urandom);
        alu  = $urandom; dmem = $urandom; pc4 = $urandom;
        #3;
        check("rnd_wb", wbByp, modelWb());
        check("rnd_rs1_byp", rs1Byp, modelRead(rs1, 1'b1));
        check("rnd_rs2_byp", rs2Byp, modelRead(rs2, 1'b1));
        check("rnd_rs1_raw", rs1Raw, modelRead(rs1, 1'b0));
        check("rnd_rs2_raw", rs2Raw, modelRead(rs2, 1'b0));
        check("rnd_dbg", dbgByp, modelRead(dbgA, 1'b0));
        tick();
        check("rnd_cnt_byp", cntByp, modelCnt);
        check("rnd_cnt_raw", cntRaw, modelCnt);
        check("rnd_dbg_post", dbgRaw, modelRead(dbgA, 1'b0));
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] expWb;
    } muxVec_t;

    muxVec_t muxTab [4];

    initial begin
        muxTab[0] = '{2'b00, 32'h0000_1234};
        muxTab[1] = '{2'b01, 32'h0000_BEEF};
        muxTab[2] = '{2'b10, 32'h0000_0040};
        muxTab[3] = '{2'b11, 32'h0000_0000};

        foreach (modelRegs[i]) modelRegs[i] = 32'hDEAD_0000;
        modelCnt = 32'hDEAD_0000;
        rst = 1'b1; we = 1'b0; rd = '0; rs1 = '0; rs2 = '0; dbgA = '0;
        sel = 2'b00; alu = '0; dmem = '0; pc4 = '0;

        // Reset held for two cycles, then every entry and the counter read back 0.
        #1;
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            dbgA = 5'(a);
            #1;
            check("reset_dbg", dbgByp, 32'd0);
        end
        check("reset_cnt", cntByp, 32'd0);
        check("reset_cnt_raw", cntRaw, 32'd0);

        // Source mux across all four selects into x5.
        alu = 32'h1234; dmem = 32'hBEEF; pc4 = 32'h40;
        for (int i = 0; i < 4; i++) begin
            drive(5'd5, 32'h1234, muxTab[i].sel, 1'b1, 5'd0, 5'd0, 5'd5);
            check("mux_wb", wbByp, muxTab[i].expWb);
            tick();
            check("mux_dbg_x5", dbgByp, muxTab[i].expWb);
        end
        check("mux_cnt", cntByp, 32'd4);

        // Writes to x0 are dropped and uncounted.
        drive(5'd0, 32'hFFFF_FFFF, 2'b00, 1'b1, 5'd0, 5'd0, 5'd0);
        check("x0_rs1_pre", rs1Byp, 32'd0);
        tick();
        check("x0_rs1", rs1Byp, 32'd0);
        check("x0_dbg", dbgByp, 32'd0);
        check("x0_cnt", cntByp, 32'd4);

        // Bypass vs. stored value on x7.
        drive(5'd7, 32'h11, 2'b00, 1'b1, 5'd0, 5'd0, 5'd7);
        tick();
        drive(5'd7, 32'h22, 2'b00, 1'b1, 5'd7, 5'd7, 5'd7);
        check("byp_rs1", rs1Byp, 32'h22);
        check("byp_rs2", rs2Byp, 32'h22);
        check("byp_dbg", dbgByp, 32'h11);
        check("nobyp_rs1", rs1Raw, 32'h11);
        check("nobyp_rs2", rs2Raw, 32'h11);
        tick();
        we = 1'b0;
        #1;
        check("post_rs1_raw", rs1Raw, 32'h22);
        check("post_dbg", dbgByp, 32'h22);
        check("byp_cnt", cntByp, 32'd6);

        // RegWrite low: no write, no bypass, no count.
        drive(5'd3, 32'h99, 2'b00, 1'b0, 5'd3, 5'd3, 5'd3);
        check("nowe_rs1", rs1Byp, 32'd0);
        tick();
        check("nowe_dbg", dbgByp, 32'd0);
        check("nowe_cnt", cntByp, 32'd6);

        // Reset on the same edge as a commit to x9.
        drive(5'd9, 32'h77, 2'b00, 1'b1, 5'd0, 5'd0, 5'd9);
        tick();
        check("pre_rst_x9", dbgByp, 32'h77);
        rst = 1'b1;
        drive(5'd9, 32'h55, 2'b00, 1'b1, 5'd9, 5'd9, 5'd9);
        check("rst_nobyp_rs1", rs1Byp, 32'h77);
        tick();
        check("rst_rs1_x9", rs1Byp, 32'd0);
        check("rst_dbg_x9", dbgByp, 32'd0);
        check("rst_cnt", cntByp, 32'd0);
        tick();
        rst = 1'b0;
        we  = 1'b0;
        #1;

        for (int n = 0; n < 400; n++)
            randomStep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
